afifo_wr_logic: RTL and testbench

AFIFO_WR_LOGIC -- requirements
Module: afifo_wr_logic

---
 rtl/afifo_pkg.sv | 12 +
 rtl/bin2gray.sv | 11 +
 rtl/gray2bin.sv | 17 +
 rtl/afifo_wr_logic.sv | 70 +++++++
 tb/tb_afifo_wr_logic.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared parameters for both sides of the async FIFO.
// Keeping the pointer-width derivation here makes both sides agree on it.
package afifo_pkg;

    localparam int AFIFO_AW_DEF = 27;

    // One wrap bit above the address separates full from empty.
    function automatic int afifo_pw(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to Gray code conversion, purely combinational.
module bin2gray #(
    parameter int W = 4
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray2bin.sv
// Gray to binary code conversion, purely combinational.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/afifo_wr_logic.sv
// Write-side control of the async FIFO: write pointer, Gray export, full/almost-full,
// occupancy and a sticky overflow flag, all in the wclk domain.
module afifo_wr_logic
    import afifo_pkg::*;
#(
    parameter int AW        = AFIFO_AW_DEF,
    parameter int PW        = afifo_pw(AW),
    parameter int AF_THRESH = (2**AW) - 2
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          ovf_clr,
    input  logic [PW-1:0] rd_gray_ptr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [PW-1:0] wr_gray_ptr,
    output logic          full,
    output logic          almost_full,
    output logic [PW-1:0] wr_count,
    output logic          overflow
);

    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] wr_gray_nxt;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_ptr_q;

    assign wr_en      = push && !full;
    assign wr_addr    = wr_ptr_q[AW-1:0];
    assign wr_ptr_nxt = wr_ptr_q + PW'(wr_en);

    bin2gray #(.W(PW)) u_bin2gray (
        .bin  (wr_ptr_nxt),
        .gray (wr_gray_nxt)
    );

    gray2bin #(.W(PW)) u_gray2bin (
        .gray (rd_gray_ptr),
        .bin  (rd_bin)
    );

    // Status uses the registered read pointer, so it can only lag toward "fuller".
    assign full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_count    = wr_ptr_q - rd_ptr_q;
    assign almost_full = (wr_count >= AF_LVL);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            wr_gray_ptr <= '0;
            rd_ptr_q    <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_nxt;
            wr_gray_ptr <= wr_gray_nxt;
            rd_ptr_q    <= rd_bin;
            if (push && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_afifo_wr_logic.sv
// Directed bench for afifo_wr_logic with a 4-entry FIFO and almost_full at 3.
module tb_afifo_wr_logic;

    logic       wclk;
    logic       rst_n;
    logic       push;
    logic       ovf_clr;
    logic [2:0] rd_gray_ptr;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_gray_ptr;
    logic       full;
    logic       almost_full;
    logic [2:0] wr_count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    afifo_wr_logic #(.AW(2), .PW(3), .AF_THRESH(3)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .push        (push),
        .ovf_clr     (ovf_clr),
        .rd_gray_ptr (rd_gray_ptr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_gray_ptr (wr_gray_ptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_count    (wr_count),
        .overflow    (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [2:0] to_gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [2:0] exp_wr;
    logic [2:0] exp_rdq;
    logic [2:0] rd_bin;
    logic [2:0] prev_gray;
    logic       acc;
    logic       saw_wrap;

    initial begin
        rst_n       = 1'b0;
        push        = 1'b0;
        ovf_clr     = 1'b0;
        rd_gray_ptr = 3'b000;
        #2;
        chk("rst_wr_en",   wr_en, 0);
        chk("rst_addr",    wr_addr, 0);
        chk("rst_full",    full, 0);
        chk("rst_af",      almost_full, 0);
        chk("rst_count",   wr_count, 0);
        chk("rst_ovf",     overflow, 0);
        chk("rst_gray",    wr_gray_ptr, 0);
        push = 1'b1;
        #1;
        chk("rst_wr_en_push", wr_en, 1);
        push = 1'b0;
        @(posedge wclk);
        #3 rst_n = 1'b1;
        step();

        // Four back-to-back pushes with the reader idle.
        push = 1'b1;
        #1;
        chk("p0_wr_en", wr_en, 1);
        chk("p0_addr",  wr_addr, 0);
        step();
        chk("p1_addr",  wr_addr, 1);
        chk("p1_count", wr_count, 1);
        chk("p1_gray",  wr_gray_ptr, 3'b001);
        step();
        chk("p2_addr",  wr_addr, 2);
        chk("p2_count", wr_count, 2);
        chk("p2_gray",  wr_gray_ptr, 3'b011);
        chk("p2_af",    almost_full, 0);
        step();
        chk("p3_addr",  wr_addr, 3);
        chk("p3_count", wr_count, 3);
        chk("p3_gray",  wr_gray_ptr, 3'b010);
        chk("p3_af",    almost_full, 1);
        chk("p3_full",  full, 0);
        step();
        chk("p4_full",  full, 1);
        chk("p4_count", wr_count, 4);
        chk("p4_gray",  wr_gray_ptr, 3'b110);
        chk("p4_addr",  wr_addr, 0);
        chk("p4_ovf",   overflow, 0);

        // Fifth push while full is dropped and flags overflow.
        chk("ovf_wr_en", wr_en, 0);
        step();
        chk("ovf_set",   overflow, 1);
        chk("ovf_addr",  wr_addr, 0);
        chk("ovf_count", wr_count, 4);
        chk("ovf_gray",  wr_gray_ptr, 3'b110);
        ovf_clr = 1'b1;
        step();
        chk("ovf_set_prio", overflow, 1);
        push = 1'b0;
        step();
        chk("ovf_cleared", overflow, 0);
        ovf_clr = 1'b0;

        // Reader frees one entry; visible one edge later.
        rd_gray_ptr = 3'b001;
        #1;
        chk("rd_full_lag", full, 1);
        step();
        chk("rd_full",  full, 0);
        chk("rd_count", wr_count, 3);
        chk("rd_af",    almost_full, 1);
        push = 1'b1;
        #1;
        chk("rd_push_en",   wr_en, 1);
        chk("rd_push_addr", wr_addr, 0);
        step();
        push = 1'b0;
        chk("rd2_count", wr_count, 4);
        chk("rd2_full",  full, 1);
        chk("rd2_gray",  wr_gray_ptr, 3'b111);

        // almost_full falls when occupancy drops to 2.
        rd_gray_ptr = 3'b011;
        step();
        chk("af3_count", wr_count, 3);
        chk("af3_af",    almost_full, 1);
        rd_gray_ptr = 3'b010;
        step();
        chk("af2_count", wr_count, 2);
        chk("af2_af",    almost_full, 0);
        chk("af2_full",  full, 0);

        // 20 pushes against a reader that takes one entry every other cycle.
        exp_wr    = 3'd5;
        exp_rdq   = 3'd3;
        rd_bin    = 3'd3;
        prev_gray = 3'b111;
        saw_wrap  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push = 1'b1;
            if ((i % 2) == 1 && rd_bin != exp_wr) rd_bin = rd_bin + 3'd1;
            rd_gray_ptr = to_gray(rd_bin);
            acc = ((exp_wr - exp_rdq) != 3'd4);
            #1;
            chk($sformatf("loop%0d_wr_en", i), wr_en, acc);
            step();
            exp_wr  = exp_wr + 3'(acc);
            exp_rdq = rd_bin;
            chk($sformatf("loop%0d_gray", i), wr_gray_ptr, to_gray(exp_wr));
            chk($sformatf("loop%0d_step", i), ($countones(wr_gray_ptr ^ prev_gray) <= 1), 1);
            if (prev_gray == 3'b100 && wr_gray_ptr == 3'b000) saw_wrap = 1'b1;
            prev_gray = wr_gray_ptr;
        end
        push = 1'b0;
        chk("loop_wrap_seen", saw_wrap, 1);

        // Asynchronous reset in the middle of a cycle.
        rd_bin      = exp_wr - 3'd2;
        rd_gray_ptr = to_gray(rd_bin);
        step();
        chk("ar_pre_count", wr_count, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_count", wr_count, 0);
        chk("ar_gray",  wr_gray_ptr, 0);
        chk("ar_addr",  wr_addr, 0);
        chk("ar_full",  full, 0);
        chk("ar_af",    almost_full, 0);
        chk("ar_ovf",   overflow, 0);
        push = 1'b1;
        #1;
        chk("ar_wr_en", wr_en, 1);
        push = 1'b0;
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
